riscv_alu_exec: RTL
===================

RISCV_ALU_EXEC -- requirements
Module: riscv_alu_exec

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width in bits.
REQ-002 SHALL have port clk_i, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n_i, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port valid_i, input, 1: upstream operation valid.
REQ-005 SHALL have port ready_o, output, 1: block can accept an operation this cycle.
REQ-006 SHALL have port AluCtl_i, input, 4: ALU operation code from the ALU control decoder, encoded per define.h macros aluop_add, aluop_or, aluop_sra and aluop_nop.
REQ-007 SHALL have port op_a_i, input, XLEN: operand A.
REQ-008 SHALL have port op_b_i, input, XLEN: operand B; bits [4:0] give the shift amount for SRA.
REQ-009 SHALL have port rd_i, input, 5: destination register tag.
REQ-010 SHALL have port flush_i, input, 1: synchronous pipeline flush.
REQ-011 SHALL have port valid_o, output, 1: result valid.
REQ-012 SHALL have port ready_i, input, 1: downstream accepts the result.
REQ-013 SHALL have port result_o, output, XLEN: registered result.
REQ-014 SHALL have port rd_o, output, 5: registered tag matching result_o.
REQ-015 SHALL have port busy_o, output, 1: high while in SHIFT.

Function
REQ-016 SHALL implement states IDLE, SHIFT and DONE.
REQ-017 SHALL define accept as valid_i && ready_o && !flush_i.
REQ-018 SHALL drive ready_o = (state==IDLE) || (state==DONE && ready_i), combinationally.
REQ-019 On accept of aluop_add, SHALL load result = op_a_i + op_b_i modulo 2^XLEN, carry discarded, and go to DONE (latency 1).
REQ-020 On accept of aluop_or, SHALL load result = op_a_i | op_b_i and go to DONE.
REQ-021 On accept of aluop_nop or any undefined code, SHALL load result = 0, keep rd, and go to DONE.
REQ-022 On accept of aluop_sra with shamt = op_b_i[4:0] = 0, SHALL load result = op_a_i and go to DONE.
REQ-023 On accept of aluop_sra with shamt = k > 0, SHALL load result = op_a_i, counter = k, and go to SHIFT.
REQ-024 In SHIFT, each cycle SHALL shift result right arithmetically by 1 (MSB replicated) and decrement the counter.
REQ-025 SHALL leave SHIFT for DONE on the cycle the counter reaches 0, so valid_o rises k+1 cycles after accept.
REQ-026 SHALL assert valid_o only in DONE, and SHALL hold result_o and rd_o stable while valid_o && !ready_i.
REQ-027 In DONE with ready_i: on accept, SHALL load the new operation (back-to-back, no bubble); otherwise SHALL go to IDLE.
REQ-028 In IDLE, valid_o SHALL be 0; result_o and rd_o SHALL retain their last values.
REQ-029 flush_i SHALL have priority over everything else: next state IDLE, valid_o=0, counter=0, any in-flight or same-cycle input discarded.
REQ-030 valid_i arriving in SHIFT SHALL NOT be accepted (ready_o=0); upstream SHALL hold it.

Reset
REQ-031 While rst_n_i=0, state SHALL be IDLE, and valid_o, busy_o, result_o, rd_o and the counter SHALL all be 0.
REQ-032 Reset asserted mid-SHIFT SHALL abort the operation immediately, with no result emitted.
REQ-033 The first accept SHALL be possible on the first rising edge after rst_n_i deasserts.

Verification
REQ-034 ADD 0xFFFFFFFF + 0x00000002, rd=3, ready_i=1 -> next cycle valid_o=1, result_o=0x00000001, rd_o=3.
REQ-035 SRA op_a=0x80000000, op_b=4 -> busy_o=1 for 4 cycles, then valid_o=1 with result_o=0xF8000000, ready_o=0 throughout SHIFT.
REQ-036 OR 0x0F0F0000|0x000000FF held with ready_i=0 for 3 cycles -> result_o=0x0F0F00FF stable and valid_o=1 throughout; ready_i=1 plus a new ADD the same cycle -> next result with no bubble.
REQ-037 flush_i=1 on the 2nd SHIFT cycle of SRA shamt=8 -> next cycle state IDLE, valid_o=0, no result for that rd.
REQ-038 rst_n_i pulsed low mid-SHIFT -> all outputs 0 asynchronously, then an ADD accepted on the first post-reset edge.
REQ-039 SRA shamt=0 and an undefined AluCtl code -> latency 1, with result_o=op_a and result_o=0 respectively.

Source files
------------

// File: rtl/riscv_alu_exec.sv
// riscv_alu_exec: single-issue ALU execute stage with valid/ready handshakes on
// both sides. ADD, OR, NOP and undefined codes finish in one cycle. SRA is
// iterative: the result shifts right by one bit per cycle until the shift
// count is used up.
//
// Ports:
//   clk_i      - clock, rising edge
//   rst_n_i    - asynchronous active-low reset
//   valid_i    - upstream operation valid
//   ready_o    - stage can accept an operation this cycle
//   AluCtl_i   - ALU operation code (see Aluop* parameters)
//   op_a_i     - operand A
//   op_b_i     - operand B; [4:0] is the SRA shift amount
//   rd_i       - destination register tag
//   flush_i    - synchronous flush, overrides everything else
//   valid_o    - result valid (only in DONE)
//   ready_i    - downstream accepts the result
//   result_o   - registered result
//   rd_o       - registered tag that goes with result_o
//   busy_o     - high while an SRA is shifting
module riscv_alu_exec #(
    parameter int unsigned XLEN      = 32,
    // Opcode values from the control decoder's shared definitions
    parameter logic [3:0]  AluopAdd  = 4'b0010,
    parameter logic [3:0]  AluopOr   = 4'b0001,
    parameter logic [3:0]  AluopSra  = 4'b1000,
    parameter logic [3:0]  AluopNop  = 4'b0000
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [3:0]      AluCtl_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic [4:0]      rd_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o,
    output logic            busy_o
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    state_e            state_q;
    logic [XLEN-1:0]   result_q;
    logic [4:0]        rd_q;
    logic [4:0]        cnt_q;
    logic              valid_q;
    logic              busy_q;
    logic              accept;
    logic [4:0]        shamt;

    assign ready_o = (state_q == StIdle) || ((state_q == StDone) && ready_i);
    assign accept  = valid_i && ready_o && !flush_i;
    assign shamt   = op_b_i[4:0];

    assign valid_o  = valid_q;
    assign busy_o   = busy_q;
    assign result_o = result_q;
    assign rd_o     = rd_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= StIdle;
            result_q <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else if (flush_i) begin
            // Drop anything in flight; result_q/rd_q keep their last values.
            state_q <= StIdle;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else if (accept) begin
            // Reached from IDLE, or from DONE with ready_i (back-to-back).
            rd_q <= rd_i;
            if (AluCtl_i == AluopSra && shamt != 5'd0) begin
                result_q <= op_a_i;
                cnt_q    <= shamt;
                state_q  <= StShift;
                valid_q  <= 1'b0;
                busy_q   <= 1'b1;
            end else begin
                unique case (AluCtl_i)
                    AluopAdd: result_q <= op_a_i + op_b_i;
                    AluopOr:  result_q <= op_a_i | op_b_i;
                    AluopSra: result_q <= op_a_i;
                    default:  result_q <= '0;
                endcase
                cnt_q   <= '0;
                state_q <= StDone;
                valid_q <= 1'b1;
                busy_q  <= 1'b0;
            end
        end else begin
            unique case (state_q)
                StShift: begin
                    result_q <= {result_q[XLEN-1], result_q[XLEN-1:1]};
                    cnt_q    <= cnt_q - 5'd1;
                    // Last shift lands this cycle: result is ready next cycle.
                    if (cnt_q == 5'd1) begin
                        state_q <= StDone;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                StDone: begin
                    if (ready_i) begin
                        state_q <= StIdle;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
